// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO (shift-add multiply, restoring divide).
// Optional MULDIV_FAST_MUL_EN: single-cycle multiplier for MULT/MULTU, divide unchanged.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               is_div, neg_lo, neg_hi, dz;
   logic [WIDTH-1:0]   opb;
   logic [2*WIDTH-1:0] acc;

   // Signed ops work on magnitudes; signs are re-applied in FIX.
   logic             sa, sb;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [CNT_W-1:0] load_cnt;

   assign sa    = ~op[0] & a[WIDTH-1];
   assign sb    = ~op[0] & b[WIDTH-1];
   assign mag_a = sa ? -a : a;
   assign mag_b = sb ? -b : b;

`ifdef MULDIV_FAST_MUL_EN
   assign load_cnt = op[1] ? CNT_W'(WIDTH) : CNT_W'(1);
`else
   assign load_cnt = CNT_W'(WIDTH);
`endif

   // Multiply: acc = {partial product, remaining multiplier bits}.
   logic [2*WIDTH-1:0] mul_next;
`ifdef MULDIV_FAST_MUL_EN
   assign mul_next = {{WIDTH{1'b0}}, opb} * {{WIDTH{1'b0}}, acc[WIDTH-1:0]};
`else
   logic [WIDTH:0] mul_sum;
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
   assign mul_next = {mul_sum, acc[WIDTH-1:1]};
`endif

   // Divide: acc = {partial remainder, dividend bits shifting into quotient bits}.
   logic [WIDTH:0]     div_tr, div_diff;
   logic [2*WIDTH-1:0] div_next;
   assign div_tr   = acc[2*WIDTH-1:WIDTH-1];
   assign div_diff = div_tr - {1'b0, opb};
   assign div_next = div_diff[WIDTH] ? {div_tr[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem, res_hi, res_lo;
   assign prod   = neg_lo ? -acc : acc;
   assign quo    = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem    = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
   // Divide by zero leaves |a| as remainder, which re-signs back to the raw operand.
   assign res_hi = is_div ? rem : prod[2*WIDTH-1:WIDTH];
   assign res_lo = is_div ? (dz ? {WIDTH{1'b1}} : quo) : prod[WIDTH-1:0];

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state  <= IDLE;
         busy   <= 1'b0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
         cnt    <= '0;
         is_div <= 1'b0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
         dz     <= 1'b0;
         opb    <= '0;
         acc    <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (wr_hi) hi <= wdata;
               if (wr_lo) lo <= wdata;
               if (start) begin
                  is_div <= op[1];
                  neg_lo <= sa ^ sb;
                  neg_hi <= op[1] ? sa : (sa ^ sb);
                  dz     <= op[1] && (b == '0);
                  opb    <= op[1] ? mag_b : mag_a;
                  acc    <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                  cnt    <= load_cnt;
                  busy   <= 1'b1;
                  state  <= RUN;
               end
            end
            RUN: begin
               acc <= is_div ? div_next : mul_next;
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) state <= FIX;
            end
            FIX: begin
               hi    <= res_hi;
               lo    <= res_lo;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed, boundary, handshake and random ops vs a 64-bit arithmetic model.
module tb_muldiv_unit;

   logic        clock = 1'b0;
   logic        resetn, start, wr_hi, wr_lo, busy, done;
   logic [1:0]  op;
   logic [31:0] a, b, wdata, hi, lo;

   int checks = 0;
   int failures = 0;

   muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
      .clock(clock), .resetn(resetn), .start(start), .op(op), .a(a), .b(b),
      .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   always #5 clock = ~clock;

   function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] eh, output logic [31:0] el);
      longint p, q, r;
      logic [63:0] u;
      case (o)
         2'd0: begin p = longint'($signed(x)) * longint'($signed(y)); eh = p[63:32]; el = p[31:0]; end
         2'd1: begin u = {32'd0, x} * {32'd0, y}; eh = u[63:32]; el = u[31:0]; end
         2'd2: begin
            if (y == 0) begin eh = x; el = 32'hFFFF_FFFF; end
            else begin
               q = longint'($signed(x)) / longint'($signed(y));
               r = longint'($signed(x)) % longint'($signed(y));
               eh = r[31:0]; el = q[31:0];
            end
         end
         default: begin
            if (y == 0) begin eh = x; el = 32'hFFFF_FFFF; end
            else begin eh = x % y; el = x / y; end
         end
      endcase
   endfunction

   function automatic int exp_lat(input logic [1:0] o);
`ifdef MULDIV_FAST_MUL_EN
      return o[1] ? 33 : 2;
`else
      return 33 + 0 * o;
`endif
   endfunction

   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input string nm);
      logic [31:0] eh, el;
      int lat;
      model(o, x, y, eh, el);
      @(negedge clock);
      op = o; a = x; b = y; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL %s busy_after_start got=%b want=1", nm, busy); end
      lat = 0;
      while (lat < 100) begin
         @(posedge clock); #1;
         lat++;
         if (done === 1'b1) break;
      end
      checks++;
      if (lat !== exp_lat(o)) begin failures++; $display("FAIL %s latency got=%0d want=%0d", nm, lat, exp_lat(o)); end
      checks++;
      if (hi !== eh || lo !== el) begin
         failures++;
         $display("FAIL %s result op=%0d a=%h b=%h got hi=%h lo=%h want hi=%h lo=%h", nm, o, x, y, hi, lo, eh, el);
      end
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_at_done got=%b want=0", nm, busy); end
      @(posedge clock); #1;
      checks++;
      if (done !== 1'b0 || hi !== eh || lo !== el) begin
         failures++;
         $display("FAIL %s done_pulse_hold got done=%b hi=%h lo=%h want done=0 hi=%h lo=%h", nm, done, hi, lo, eh, el);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0; start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; op = 2'd0; a = '0; b = '0; wdata = '0;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         failures++;
         $display("FAIL reset_state got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
      end
      @(negedge clock); resetn = 1'b1;
   endtask

   task automatic test_reset_mid();
      int pulses = 0;
      @(negedge clock);
      op = 2'd1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start = 1'b1;
      @(negedge clock); start = 1'b0;
      repeat (9) @(negedge clock);
      resetn = 1'b0;
      @(posedge clock); #1;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         failures++;
         $display("FAIL reset_mid got busy=%b done=%b hi=%h lo=%h want 0 0 0 0", busy, done, hi, lo);
      end
      @(negedge clock); resetn = 1'b1;
      repeat (40) begin @(posedge clock); #1; if (done === 1'b1) pulses++; end
      checks++;
      if (pulses !== 0 || hi !== 32'd0 || lo !== 32'd0) begin
         failures++;
         $display("FAIL reset_mid_abort got pulses=%0d hi=%h lo=%h want 0 0 0", pulses, hi, lo);
      end
      run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "rerun_multu");
   endtask

   task automatic test_directed();
      run_op(2'd0, 32'hFFFF_FFF9, 32'd6, "mult_neg7x6");
      run_op(2'd2, 32'hFFFF_FFF9, 32'd2, "div_neg7_2");
      run_op(2'd3, 32'd100, 32'd7, "divu_100_7");
      run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_neg1");
      run_op(2'd3, 32'h0000_1234, 32'd0, "divu_by_zero");
      run_op(2'd2, 32'hFFFF_FF00, 32'd0, "div_neg_by_zero");
      run_op(2'd1, 32'h0001_0000, 32'h0001_0000, "multu_2p32");
      run_op(2'd3, 32'd9, 32'd3, "divu_9_3");
      run_op(2'd0, 32'h8000_0000, 32'h8000_0000, "mult_min_min");
      run_op(2'd2, 32'd7, 32'hFFFF_FFFE, "div_7_neg2");
   endtask

   task automatic test_handshake();
      int lat = 0;
      int pulses = 0;
      @(negedge clock);
      op = 2'd1; a = 32'd3; b = 32'd4; start = 1'b1;
      @(negedge clock); start = 1'b0;
      repeat (4) @(negedge clock);
      op = 2'd3; a = 32'd100; b = 32'd7; start = 1'b1; wr_lo = 1'b1; wdata = 32'h0000_DEAD;
      @(negedge clock); start = 1'b0; wr_lo = 1'b0;
      lat = 5;
      while (lat < 100) begin
         @(posedge clock); #1;
         lat++;
         if (done === 1'b1) break;
      end
      checks++;
      if (lat !== exp_lat(2'd1) || lo !== 32'd12 || hi !== 32'd0) begin
         failures++;
         $display("FAIL busy_ignore got lat=%0d hi=%h lo=%h want lat=%0d hi=0 lo=c", lat, hi, lo, exp_lat(2'd1));
      end
      repeat (40) begin @(posedge clock); #1; if (done === 1'b1) pulses++; end
      checks++;
      if (pulses !== 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL start_not_queued got pulses=%0d busy=%b want 0 0", pulses, busy);
      end
      @(negedge clock); wr_hi = 1'b1; wdata = 32'h0000_BEEF;
      @(posedge clock); #1; wr_hi = 1'b0;
      checks++;
      if (hi !== 32'h0000_BEEF || lo !== 32'd12) begin
         failures++;
         $display("FAIL mthi_idle got hi=%h lo=%h want hi=0000beef lo=0000000c", hi, lo);
      end
      @(negedge clock); wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h1357_9BDF;
      @(posedge clock); #1; wr_hi = 1'b0; wr_lo = 1'b0;
      checks++;
      if (hi !== 32'h1357_9BDF || lo !== 32'h1357_9BDF) begin
         failures++;
         $display("FAIL mthi_mtlo_both got hi=%h lo=%h want 13579bdf 13579bdf", hi, lo);
      end
      @(negedge clock); wr_lo = 1'b1; wdata = 32'h0000_5555; op = 2'd1; a = 32'd2; b = 32'd3; start = 1'b1;
      @(posedge clock); #1; wr_lo = 1'b0; start = 1'b0;
      checks++;
      if (lo !== 32'h0000_5555 || busy !== 1'b1) begin
         failures++;
         $display("FAIL write_with_start got lo=%h busy=%b want 00005555 1", lo, busy);
      end
      lat = 0;
      while (lat < 100) begin
         @(posedge clock); #1;
         lat++;
         if (done === 1'b1) break;
      end
      checks++;
      if (lat !== exp_lat(2'd1) || lo !== 32'd6 || hi !== 32'd0) begin
         failures++;
         $display("FAIL fix_overwrites got lat=%0d hi=%h lo=%h want lat=%0d hi=0 lo=6", lat, hi, lo, exp_lat(2'd1));
      end
   endtask

   task automatic test_random();
      logic [31:0] x, y;
      logic [1:0]  o;
      for (int i = 0; i < 40; i++) begin
         o = 2'($urandom_range(0, 3));
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 7))
            0: y = 32'd0;
            1: y = 32'($urandom_range(1, 15));
            2: x = 32'h8000_0000;
            3: y = 32'hFFFF_FFFF;
            default: ;
         endcase
         run_op(o, x, y, "random");
      end
   endtask

   task automatic test_back_to_back();
      run_op(2'd0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, "b2b_0");
      run_op(2'd2, 32'hFFFF_FFFF, 32'd1, "b2b_1");
      run_op(2'd1, 32'hDEAD_BEEF, 32'h1234_5678, "b2b_2");
   endtask

   initial begin
      test_reset();
      test_reset_mid();
      test_directed();
      test_handshake();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
